// File: rtl/perf_monitor.sv
// -----------------------------------------------------------------------------
// perf_monitor
//
// Performance counter block fed by the per-cycle pipeline status of the MIPS
// core. Once a run starts it counts cycles, issued instructions, load-use
// stalls, branches, taken branches and (optionally) branch-predictor gain and
// loss events. A run ends on the halt instruction or on a cycle limit. The
// frozen counters are read back through a registered read port.
//
// Parameters:
//   WIDTH      - width of every counter and of rd_data (must be >= 4 so the
//                status word fits)
//   MAX_CYCLES - cycle limit; reaching it ends the run with timeout set
//   HALT_INST  - instruction word that ends a run
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   start           in   one-cycle pulse, IDLE -> RUN
//   clear           in   synchronous clear of all counters/flags, -> IDLE
//   inst_IF         in   [31:0] instruction word in IF
//   hazard_detected in   pipeline stalled this cycle
//   MEM_R_EN_EXE    in   instruction in EXE is a load
//   is_branch_ID    in   instruction in ID is BEQ/BNE
//   Br_Taken_ID     in   branch in ID resolved taken
//   bp_pred_ID      in   predictor said taken for branch in ID
//   rd_addr         in   [2:0] counter select
//                        0 cycles, 1 instrs, 2 load_use, 3 branches,
//                        4 taken, 5 bp_gain, 6 bp_loss, 7 status
//   rd_data         out  [WIDTH-1:0] registered read data
//   running         out  FSM is in RUN
//   done            out  FSM is in DONE
//
// Build option:
//   PERF_BP_STATS_EN - when defined, the bp_gain/bp_loss counters exist.
//                      When undefined they are not built, bp_pred_ID is
//                      unused, addresses 5/6 read 0 and sat ignores them.
// -----------------------------------------------------------------------------
module perf_monitor #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_CYCLES = 100000,
    parameter logic [31:0] HALT_INST  = 32'hA800FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [31:0]      inst_IF,
    input  logic             hazard_detected,
    input  logic             MEM_R_EN_EXE,
    input  logic             is_branch_ID,
    input  logic             Br_Taken_ID,
    input  logic             bp_pred_ID,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             running,
    output logic             done
);

`ifdef PERF_BP_STATS_EN
    localparam int NUM_CNT = 7;
`else
    localparam int NUM_CNT = 5;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   timeout_reg, timeout_next;
    logic   sat_reg, sat_next;
    logic   running_reg, done_reg;
    logic [WIDTH-1:0] rd_data_reg, rd_data_next;

    logic [WIDTH-1:0] cnt_reg  [NUM_CNT];
    logic [WIDTH-1:0] cnt_next [NUM_CNT];

    logic [NUM_CNT-1:0] inc;
    logic [NUM_CNT-1:0] bump;
    logic [NUM_CNT-1:0] at_max;
    logic [NUM_CNT-1:0] sat_hit;

    logic is_halt;
    logic count_en;
    logic limit_hit;
    logic br;

`ifndef PERF_BP_STATS_EN
    // Predictor input has no consumer in this build.
    logic unused_bp_pred;
    assign unused_bp_pred = bp_pred_ID;
`endif

    assign is_halt  = (inst_IF == HALT_INST);
    // The halting cycle and a clearing cycle are never counted.
    assign count_en = (state_reg == S_RUN) && !is_halt && !clear;
    // Compared at 64 bits so a narrow counter can never alias the limit.
    assign limit_hit = (64'(cnt_reg[0]) == (64'(MAX_CYCLES) - 64'd1));
    assign br        = !hazard_detected && is_branch_ID;

    // Per-counter increment conditions.
    always_comb begin
        inc    = '0;
        inc[0] = 1'b1;
        inc[1] = !hazard_detected && (inst_IF != 32'd0);
        inc[2] = hazard_detected && MEM_R_EN_EXE;
        inc[3] = br;
        inc[4] = br && Br_Taken_ID;
`ifdef PERF_BP_STATS_EN
        inc[5] = br && bp_pred_ID && Br_Taken_ID;
        inc[6] = br && bp_pred_ID && !Br_Taken_ID;
`endif
    end

    // Saturating counters: an increment at all-ones holds the value and
    // raises the sticky sat flag instead of wrapping.
    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            assign bump[gi]     = count_en && inc[gi];
            assign at_max[gi]   = &cnt_reg[gi];
            assign sat_hit[gi]  = bump[gi] && at_max[gi];
            assign cnt_next[gi] = clear ? '0 :
                                  (bump[gi] && !at_max[gi]) ? cnt_reg[gi] + WIDTH'(1) :
                                  cnt_reg[gi];
        end
    endgenerate

    assign sat_next = clear ? 1'b0 : (sat_reg || (|sat_hit));

    // Next-state logic.
    always_comb begin
        state_next   = state_reg;
        timeout_next = timeout_reg;
        if (clear) begin
            state_next   = S_IDLE;
            timeout_next = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    // Halt takes precedence over the cycle limit.
                    if (is_halt) begin
                        state_next = S_DONE;
                    end else if (limit_hit) begin
                        state_next   = S_DONE;
                        timeout_next = 1'b1;
                    end
                end
                S_DONE: begin
                    state_next = S_DONE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Read mux works on post-update values so rd_data shows the state after
    // the edge that captured rd_addr.
    always_comb begin
        rd_data_next = '0;
        case (rd_addr)
            3'd0: rd_data_next = cnt_next[0];
            3'd1: rd_data_next = cnt_next[1];
            3'd2: rd_data_next = cnt_next[2];
            3'd3: rd_data_next = cnt_next[3];
            3'd4: rd_data_next = cnt_next[4];
`ifdef PERF_BP_STATS_EN
            3'd5: rd_data_next = cnt_next[5];
            3'd6: rd_data_next = cnt_next[6];
`endif
            3'd7: begin
                rd_data_next[3:0] = {sat_next, timeout_next,
                                     (state_next == S_DONE),
                                     (state_next == S_RUN)};
            end
            default: rd_data_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            timeout_reg <= 1'b0;
            sat_reg     <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
            rd_data_reg <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            timeout_reg <= timeout_next;
            sat_reg     <= sat_next;
            running_reg <= (state_next == S_RUN);
            done_reg    <= (state_next == S_DONE);
            rd_data_reg <= rd_data_next;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    assign rd_data = rd_data_reg;
    assign running = running_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_perf_monitor.sv
// -----------------------------------------------------------------------------
// tb_perf_monitor
//
// Directed testbench for perf_monitor. Three instances share one stimulus
// bus: u_main (default parameters), u_lim (MAX_CYCLES = 8) and u_sat
// (WIDTH = 4). Each test task resets, drives a short run and compares
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_perf_monitor;

    localparam logic [31:0] HALT = 32'hA800FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic [31:0] inst_IF;
    logic        hazard_detected;
    logic        MEM_R_EN_EXE;
    logic        is_branch_ID;
    logic        Br_Taken_ID;
    logic        bp_pred_ID;
    logic [2:0]  rd_addr;

    logic [31:0] rd_data_m, rd_data_l;
    logic [3:0]  rd_data_s;
    logic        running_m, running_l, running_s;
    logic        done_m, done_l, done_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    perf_monitor u_main (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .inst_IF(inst_IF),
        .hazard_detected(hazard_detected), .MEM_R_EN_EXE(MEM_R_EN_EXE),
        .is_branch_ID(is_branch_ID), .Br_Taken_ID(Br_Taken_ID),
        .bp_pred_ID(bp_pred_ID), .rd_addr(rd_addr), .rd_data(rd_data_m),
        .running(running_m), .done(done_m)
    );

    perf_monitor #(.MAX_CYCLES(8)) u_lim (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .inst_IF(inst_IF),
        .hazard_detected(hazard_detected), .MEM_R_EN_EXE(MEM_R_EN_EXE),
        .is_branch_ID(is_branch_ID), .Br_Taken_ID(Br_Taken_ID),
        .bp_pred_ID(bp_pred_ID), .rd_addr(rd_addr), .rd_data(rd_data_l),
        .running(running_l), .done(done_l)
    );

    perf_monitor #(.WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .inst_IF(inst_IF),
        .hazard_detected(hazard_detected), .MEM_R_EN_EXE(MEM_R_EN_EXE),
        .is_branch_ID(is_branch_ID), .Br_Taken_ID(Br_Taken_ID),
        .bp_pred_ID(bp_pred_ID), .rd_addr(rd_addr), .rd_data(rd_data_s),
        .running(running_s), .done(done_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_addr = a;
        step();
    endtask

    task automatic idle_inputs();
        start = 1'b0; clear = 1'b0; inst_IF = 32'd0;
        hazard_detected = 1'b0; MEM_R_EN_EXE = 1'b0; is_branch_ID = 1'b0;
        Br_Taken_ID = 1'b0; bp_pred_ID = 1'b0; rd_addr = 3'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (running_m !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", running_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done_m); end
        checks++; if (rd_data_m !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data_m); end
        rd(3'd7);
        checks++; if (rd_data_m !== 32'd0) begin errors++; $display("FAIL reset_status: got %0h expected 0", rd_data_m); end
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        do_reset();
        rd_addr = 3'd0;
        start = 1'b1; inst_IF = 32'd1;
        step();
        start = 1'b0;
        checks++; if (running_m !== 1'b1) begin errors++; $display("FAIL basic_running: got %0b expected 1", running_m); end
        checks++; if (rd_data_m !== 32'd0) begin errors++; $display("FAIL basic_first_read: got %0d expected 0", rd_data_m); end
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++; if (rd_data_m !== 32'(k)) begin errors++; $display("FAIL basic_cycles_live: got %0d expected %0d", rd_data_m, k); end
        end
        inst_IF = HALT;
        step();
        inst_IF = 32'd0;
        checks++; if (done_m !== 1'b1 || running_m !== 1'b0) begin errors++; $display("FAIL basic_done: got done=%0b running=%0b expected 1/0", done_m, running_m); end
        checks++; if (rd_data_m !== 32'd10) begin errors++; $display("FAIL basic_halt_not_counted: got %0d expected 10", rd_data_m); end
        rd(3'd1);
        checks++; if (rd_data_m !== 32'd10) begin errors++; $display("FAIL basic_instrs: got %0d expected 10", rd_data_m); end
        rd(3'd7);
        checks++; if (rd_data_m !== 32'h2) begin errors++; $display("FAIL basic_status: got %0h expected 2", rd_data_m); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done_m !== 1'b1 || running_m !== 1'b0) begin errors++; $display("FAIL basic_start_in_done: got done=%0b running=%0b expected 1/0", done_m, running_m); end
        $display("test_basic complete");
    endtask

    task automatic test_load_use();
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        rd(3'd7);
        checks++; if (rd_data_m !== 32'h1) begin errors++; $display("FAIL lu_status_run: got %0h expected 1", rd_data_m); end
        inst_IF = 32'd1;
        repeat (2) step();
        hazard_detected = 1'b1; MEM_R_EN_EXE = 1'b1;
        repeat (3) step();
        MEM_R_EN_EXE = 1'b0;
        repeat (2) step();
        hazard_detected = 1'b0; inst_IF = HALT;
        step();
        inst_IF = 32'd0;
        rd(3'd0);
        checks++; if (rd_data_m !== 32'd8) begin errors++; $display("FAIL lu_cycles: got %0d expected 8", rd_data_m); end
        rd(3'd1);
        checks++; if (rd_data_m !== 32'd2) begin errors++; $display("FAIL lu_instrs: got %0d expected 2", rd_data_m); end
        rd(3'd2);
        checks++; if (rd_data_m !== 32'd3) begin errors++; $display("FAIL lu_load_use: got %0d expected 3", rd_data_m); end
        $display("test_load_use complete");
    endtask

    task automatic test_branches();
        logic [31:0] exp_gain;
        logic [31:0] exp_loss;
`ifdef PERF_BP_STATS_EN
        exp_gain = 32'd1; exp_loss = 32'd1;
`else
        exp_gain = 32'd0; exp_loss = 32'd0;
`endif
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        is_branch_ID = 1'b1;
        bp_pred_ID = 1'b1; Br_Taken_ID = 1'b1; step();
        bp_pred_ID = 1'b1; Br_Taken_ID = 1'b0; step();
        bp_pred_ID = 1'b0; Br_Taken_ID = 1'b1; step();
        bp_pred_ID = 1'b0; Br_Taken_ID = 1'b0; step();
        // Stalled branch must not count anywhere.
        hazard_detected = 1'b1; bp_pred_ID = 1'b1; Br_Taken_ID = 1'b1; step();
        idle_inputs();
        inst_IF = HALT; step(); inst_IF = 32'd0;
        rd(3'd0);
        checks++; if (rd_data_m !== 32'd5) begin errors++; $display("FAIL br_cycles: got %0d expected 5", rd_data_m); end
        rd(3'd3);
        checks++; if (rd_data_m !== 32'd4) begin errors++; $display("FAIL br_branches: got %0d expected 4", rd_data_m); end
        rd(3'd4);
        checks++; if (rd_data_m !== 32'd2) begin errors++; $display("FAIL br_taken: got %0d expected 2", rd_data_m); end
        rd(3'd5);
        checks++; if (rd_data_m !== exp_gain) begin errors++; $display("FAIL br_bp_gain: got %0d expected %0d", rd_data_m, exp_gain); end
        rd(3'd6);
        checks++; if (rd_data_m !== exp_loss) begin errors++; $display("FAIL br_bp_loss: got %0d expected %0d", rd_data_m, exp_loss); end
        rd(3'd2);
        checks++; if (rd_data_m !== 32'd0) begin errors++; $display("FAIL br_load_use: got %0d expected 0", rd_data_m); end
        $display("test_branches complete");
    endtask

    task automatic test_timeout();
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        inst_IF = 32'd1;
        repeat (7) step();
        checks++; if (running_l !== 1'b1) begin errors++; $display("FAIL to_running_before_limit: got %0b expected 1", running_l); end
        step();
        checks++; if (done_l !== 1'b1) begin errors++; $display("FAIL to_done_at_limit: got %0b expected 1", done_l); end
        repeat (4) step();
        inst_IF = 32'd0;
        rd(3'd0);
        checks++; if (rd_data_l !== 32'd8) begin errors++; $display("FAIL to_cycles: got %0d expected 8", rd_data_l); end
        rd(3'd7);
        checks++; if (rd_data_l !== 32'h6) begin errors++; $display("FAIL to_status: got %0h expected 6", rd_data_l); end

        // Halt on the limit cycle wins: no timeout, halt cycle uncounted.
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        inst_IF = 32'd1;
        repeat (7) step();
        inst_IF = HALT; step(); inst_IF = 32'd0;
        checks++; if (done_l !== 1'b1) begin errors++; $display("FAIL to_halt_done: got %0b expected 1", done_l); end
        rd(3'd0);
        checks++; if (rd_data_l !== 32'd7) begin errors++; $display("FAIL to_halt_cycles: got %0d expected 7", rd_data_l); end
        rd(3'd7);
        checks++; if (rd_data_l !== 32'h2) begin errors++; $display("FAIL to_halt_status: got %0h expected 2", rd_data_l); end
        $display("test_timeout complete");
    endtask

    task automatic test_saturation();
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        inst_IF = 32'd1;
        repeat (20) step();
        inst_IF = HALT; step(); inst_IF = 32'd0;
        rd(3'd0);
        checks++; if (rd_data_s !== 4'hF) begin errors++; $display("FAIL sat_cycles: got %0d expected 15", rd_data_s); end
        checks++; if (rd_data_m !== 32'd20) begin errors++; $display("FAIL sat_wide_cycles: got %0d expected 20", rd_data_m); end
        rd(3'd1);
        checks++; if (rd_data_s !== 4'hF) begin errors++; $display("FAIL sat_instrs: got %0d expected 15", rd_data_s); end
        rd(3'd7);
        checks++; if (rd_data_s !== 4'hA) begin errors++; $display("FAIL sat_status: got %0h expected a", rd_data_s); end
        checks++; if (rd_data_m !== 32'h2) begin errors++; $display("FAIL sat_wide_status: got %0h expected 2", rd_data_m); end
        $display("test_saturation complete");
    endtask

    task automatic test_async_reset();
        do_reset();
        rd_addr = 3'd0;
        start = 1'b1; step(); start = 1'b0;
        inst_IF = 32'd1;
        repeat (5) step();
        checks++; if (rd_data_m !== 32'd5) begin errors++; $display("FAIL ar_before: got %0d expected 5", rd_data_m); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (running_m !== 1'b0 || done_m !== 1'b0 || rd_data_m !== 32'd0) begin errors++; $display("FAIL ar_main_cleared: got running=%0b done=%0b rd=%0h expected 0/0/0", running_m, done_m, rd_data_m); end
        checks++; if (running_s !== 1'b0 || rd_data_s !== 4'd0 || running_l !== 1'b0 || rd_data_l !== 32'd0) begin errors++; $display("FAIL ar_others_cleared: got rs=%0b ds=%0h rl=%0b dl=%0h expected 0", running_s, rd_data_s, running_l, rd_data_l); end
        #1;
        rst = 1'b0;
        inst_IF = 32'd0;
        rd(3'd0);
        checks++; if (rd_data_m !== 32'd0 || running_m !== 1'b0) begin errors++; $display("FAIL ar_after: got rd=%0d running=%0b expected 0/0", rd_data_m, running_m); end
        $display("test_async_reset complete");
    endtask

    task automatic test_clear();
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        inst_IF = 32'd1; is_branch_ID = 1'b1; Br_Taken_ID = 1'b1;
        repeat (3) step();
        idle_inputs();
        inst_IF = HALT; step(); inst_IF = 32'd0;
        checks++; if (done_m !== 1'b1) begin errors++; $display("FAIL clr_pre_done: got %0b expected 1", done_m); end
        // Clear beats a simultaneous start.
        clear = 1'b1; start = 1'b1; step();
        clear = 1'b0; start = 1'b0;
        checks++; if (done_m !== 1'b0 || running_m !== 1'b0) begin errors++; $display("FAIL clr_idle: got done=%0b running=%0b expected 0/0", done_m, running_m); end
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            checks++; if (rd_data_m !== 32'd0) begin errors++; $display("FAIL clr_read_addr%0d: got %0h expected 0", a, rd_data_m); end
        end
        // Clear mid-run: the clearing edge is not counted.
        start = 1'b1; step(); start = 1'b0;
        inst_IF = 32'd1;
        repeat (3) step();
        clear = 1'b1; step(); clear = 1'b0;
        inst_IF = 32'd0;
        rd(3'd0);
        checks++; if (rd_data_m !== 32'd0 || running_m !== 1'b0) begin errors++; $display("FAIL clr_midrun: got rd=%0d running=%0b expected 0/0", rd_data_m, running_m); end
        $display("test_clear complete");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_load_use();
        test_branches();
        test_timeout();
        test_saturation();
        test_async_reset();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
